procyon_ccu_sched: RTL

Starvation-aware scheduler that shares the single BIU between CCU requesters (victim queue, miss handling queue, instruction fetch queue).
- Base policy is fixed priority, lowest index wins.
- Two overrides: a per-requester urgent input (e.g. victim-queue-full), and an aging counter that promotes any requester passed over too often.
- Holds one BIU transaction at a time. Latches the winning request and returns read data with a one-cycle done pulse.

---
 rtl/procyon_ccu_pkg.sv | 48 ++++
 rtl/procyon_ccu_sched_pick.sv | 36 +++
 rtl/procyon_ccu_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/procyon_ccu_pkg.sv
// Shared types and constants for the CCU scheduler: FSM state encoding, BIU
// function/length encodings and the aging-counter width helper.
`ifndef PCYN_CCU_LEN_WIDTH
`define PCYN_CCU_LEN_WIDTH 4
`endif
`ifndef PCYN_BIU_LEN_WIDTH
`define PCYN_BIU_LEN_WIDTH 4
`endif
`ifndef PCYN_BIU_FUNC_WIDTH
`define PCYN_BIU_FUNC_WIDTH 2
`endif
`ifndef PCYN_BIU_FUNC_READ
`define PCYN_BIU_FUNC_READ 2'b01
`endif
`ifndef PCYN_BIU_FUNC_WRITE
`define PCYN_BIU_FUNC_WRITE 2'b10
`endif

package procyon_ccu_pkg;

    localparam int CCU_LEN_WIDTH  = `PCYN_CCU_LEN_WIDTH;
    localparam int BIU_LEN_WIDTH  = `PCYN_BIU_LEN_WIDTH;
    localparam int BIU_FUNC_WIDTH = `PCYN_BIU_FUNC_WIDTH;

    localparam logic [BIU_FUNC_WIDTH-1:0] BIU_FUNC_READ  = `PCYN_BIU_FUNC_READ;
    localparam logic [BIU_FUNC_WIDTH-1:0] BIU_FUNC_WRITE = `PCYN_BIU_FUNC_WRITE;

    typedef enum logic [1:0] {
        SCHED_IDLE = 2'd0,
        SCHED_BUSY = 2'd1,
        SCHED_DONE = 2'd2
    } sched_state_t;

    function automatic int age_width(input int limit);
        return $clog2(limit + 1);
    endfunction

    // Zero-extends or truncates a requester length onto the BIU length field.
    function automatic logic [BIU_LEN_WIDTH-1:0] to_biu_len(input logic [CCU_LEN_WIDTH-1:0] len);
        logic [BIU_LEN_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < BIU_LEN_WIDTH; i++) begin
            if (i < CCU_LEN_WIDTH) r[i] = len[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/procyon_ccu_sched_pick.sv
// Three-class priority picker: urgent, then starved, then plain valid; lowest
// index wins inside the first non-empty class.
module procyon_ccu_sched_pick #(
    parameter int DEPTH = 3
) (
    input  logic [DEPTH-1:0] valid,
    input  logic [DEPTH-1:0] urgent,
    input  logic [DEPTH-1:0] starved,
    output logic [DEPTH-1:0] grant,
    output logic             any_valid
);

    logic [DEPTH-1:0] urgent_mask;
    logic [DEPTH-1:0] starved_mask;
    logic [DEPTH-1:0] class_mask;
    logic             found;

    always_comb begin
        urgent_mask  = valid & urgent;
        starved_mask = valid & starved;
        if (|urgent_mask)       class_mask = urgent_mask;
        else if (|starved_mask) class_mask = starved_mask;
        else                    class_mask = valid;

        grant = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (class_mask[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        any_valid = |valid;
    end

endmodule

// File: rtl/procyon_ccu_sched.sv
// Starvation-aware scheduler sharing one BIU between CCU requesters; holds a
// single latched transaction and returns read data with a one-cycle done pulse.
//
//   state | meaning
//   IDLE  | arbitrate among valid requesters, latch the winner
//   BUSY  | BIU request held from latched fields until i_biu_done
//   DONE  | one-cycle done pulse; blocks re-arbitration on stale valid
module procyon_ccu_sched
    import procyon_ccu_pkg::*;
#(
    parameter int OPTN_ADDR_WIDTH      = 32,
    parameter int OPTN_CCU_SCHED_DEPTH = 3,
    parameter int OPTN_CCU_LINE_SIZE   = 32,
    parameter int OPTN_STARVE_LIMIT    = 4
) (
    input  logic                                          clk,
    input  logic                                          n_rst,
    input  logic [OPTN_CCU_SCHED_DEPTH-1:0]               i_req_valid,
    input  logic [OPTN_CCU_SCHED_DEPTH-1:0]               i_req_urgent,
    input  logic [OPTN_CCU_SCHED_DEPTH-1:0]               i_req_we,
    input  logic [OPTN_CCU_SCHED_DEPTH*CCU_LEN_WIDTH-1:0] i_req_len,
    input  logic [OPTN_CCU_SCHED_DEPTH*OPTN_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [OPTN_CCU_SCHED_DEPTH*OPTN_CCU_LINE_SIZE*8-1:0] i_req_data,
    output logic [OPTN_CCU_SCHED_DEPTH-1:0]               o_req_grant,
    output logic [OPTN_CCU_SCHED_DEPTH-1:0]               o_req_done,
    output logic [OPTN_CCU_LINE_SIZE*8-1:0]               o_req_data,
    input  logic                                          i_biu_done,
    input  logic [OPTN_CCU_LINE_SIZE*8-1:0]               i_biu_data,
    output logic                                          o_biu_en,
    output logic [BIU_FUNC_WIDTH-1:0]                     o_biu_func,
    output logic [BIU_LEN_WIDTH-1:0]                      o_biu_len,
    output logic [OPTN_ADDR_WIDTH-1:0]                    o_biu_addr,
    output logic [OPTN_CCU_LINE_SIZE*8-1:0]               o_biu_data
);

    localparam int DEPTH      = OPTN_CCU_SCHED_DEPTH;
    localparam int AW         = OPTN_ADDR_WIDTH;
    localparam int LINE_WIDTH = OPTN_CCU_LINE_SIZE * 8;
    localparam int AGE_W      = age_width(OPTN_STARVE_LIMIT);
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(OPTN_STARVE_LIMIT);
    localparam logic [AGE_W-1:0] AGE_ONE   = AGE_W'(1);

    sched_state_t state_q, state_d;
    logic                      load;
    logic [DEPTH-1:0]          grant_q;
    logic [BIU_FUNC_WIDTH-1:0] func_q;
    logic [BIU_LEN_WIDTH-1:0]  len_q;
    logic [AW-1:0]             addr_q;
    logic [LINE_WIDTH-1:0]     data_q;
    logic [LINE_WIDTH-1:0]     rdata_q;
    logic [AGE_W-1:0]          age_q [DEPTH];

    logic [DEPTH-1:0]          starved;
    logic [DEPTH-1:0]          pick_grant;
    logic                      pick_any;
    logic                      sel_we;
    logic [CCU_LEN_WIDTH-1:0]  sel_len;
    logic [AW-1:0]             sel_addr;
    logic [LINE_WIDTH-1:0]     sel_data;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            starved[i] = (age_q[i] == AGE_LIMIT);
        end
    end

    procyon_ccu_sched_pick #(
        .DEPTH (DEPTH)
    ) u_pick (
        .valid     (i_req_valid),
        .urgent    (i_req_urgent),
        .starved   (starved),
        .grant     (pick_grant),
        .any_valid (pick_any)
    );

    always_comb begin
        sel_we   = 1'b0;
        sel_len  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (pick_grant[i]) begin
                sel_we   = i_req_we[i];
                sel_len  = i_req_len[i*CCU_LEN_WIDTH +: CCU_LEN_WIDTH];
                sel_addr = i_req_addr[i*AW +: AW];
                sel_data = i_req_data[i*LINE_WIDTH +: LINE_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        o_biu_en   = 1'b0;
        o_req_done = '0;
        case (state_q)
            SCHED_IDLE: begin
                if (pick_any) begin
                    state_d = SCHED_BUSY;
                    load    = 1'b1;
                end
            end
            SCHED_BUSY: begin
                o_biu_en = 1'b1;
                if (i_biu_done) state_d = SCHED_DONE;
            end
            SCHED_DONE: begin
                o_req_done = grant_q;
                state_d    = SCHED_IDLE;
            end
            default: state_d = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= SCHED_IDLE;
            grant_q <= '0;
            func_q  <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                grant_q <= pick_grant;
                func_q  <= sel_we ? BIU_FUNC_WRITE : BIU_FUNC_READ;
                len_q   <= to_biu_len(sel_len);
                addr_q  <= sel_addr;
                data_q  <= sel_data;
            end
            if (state_q == SCHED_DONE) grant_q <= '0;
            if (state_q == SCHED_BUSY && i_biu_done) rdata_q <= i_biu_data;
        end
    end

    // Ages move only when a grant is issued; starved losers stay pinned at the limit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pick_grant[i])              age_q[i] <= '0;
                else if (!i_req_valid[i])       age_q[i] <= '0;
                else if (age_q[i] != AGE_LIMIT) age_q[i] <= age_q[i] + AGE_ONE;
            end
        end
    end

    assign o_req_grant = grant_q;
    assign o_req_data  = rdata_q;
    assign o_biu_func  = func_q;
    assign o_biu_len   = len_q;
    assign o_biu_addr  = addr_q;
    assign o_biu_data  = data_q;

endmodule
